// File: rtl/onchip_mem_pkg.sv
// Shared types and elaboration helpers for the pipelined dual-port on-chip RAM.
package onchip_mem_pkg;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 2;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_e;

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic bit width_ok(input int unsigned data_width);
    return (data_width != 0) && ((data_width % 8) == 0);
  endfunction

  function automatic bit latency_ok(input int unsigned lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

  // A simultaneous read+write strobe is a write.
  function automatic cmd_e decode_cmd(input logic accept, input logic rd, input logic wr);
    if (!accept) return CMD_IDLE;
    if (wr) return CMD_WRITE;
    if (rd) return CMD_READ;
    return CMD_IDLE;
  endfunction

endpackage

// File: rtl/onchip_mem_rdpipe.sv
// Per-port read return pipeline: array-output register plus READ_LATENCY stages,
// frozen while i_en is low, cleared by synchronous reset.
module onchip_mem_rdpipe
  import onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int unsigned STAGES = READ_LATENCY + 1;

  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  logic [STAGES-1:0]     r_valid;
  logic [DATA_WIDTH-1:0] r_data [STAGES];

  // Data only moves with a valid token so readdata holds the last returned word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else if (i_en) begin
      r_valid <= {r_valid[STAGES-2:0], i_valid};
      if (i_valid) begin
        r_data[0] <= i_data;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (r_valid[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  // A stalled token stays parked and re-pulses once the port is enabled again.
  assign o_valid = r_valid[STAGES-1] & i_en;
  assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/onchip_mem_dp_pipelined.sv
// True dual-port byte-enabled RAM with two Avalon-MM slaves, per-port read
// pipelines and a sticky same-address write collision flag.
module onchip_mem_dp_pipelined
  import onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "onchip_mem.hex"
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             reset_req,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [be_width(DATA_WIDTH)-1:0]  byteenable,
  input  logic                             chipselect,
  input  logic                             read,
  input  logic                             write,
  input  logic [DATA_WIDTH-1:0]            writedata,
  input  logic                             clken,
  output logic [DATA_WIDTH-1:0]            readdata,
  output logic                             readdatavalid,
  input  logic [ADDR_WIDTH-1:0]            address2,
  input  logic [be_width(DATA_WIDTH)-1:0]  byteenable2,
  input  logic                             chipselect2,
  input  logic                             read2,
  input  logic                             write2,
  input  logic [DATA_WIDTH-1:0]            writedata2,
  input  logic                             clken2,
  output logic [DATA_WIDTH-1:0]            readdata2,
  output logic                             readdatavalid2,
  output logic                             collision,
  input  logic                             collision_clr
);

  localparam int unsigned BE    = be_width(DATA_WIDTH);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (!width_ok(DATA_WIDTH)) begin : g_bad_width
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end

  // Preload from INIT_FILE is applied by the RAM implementation flow.
  if (INIT_FILE != "") begin : g_init_file
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_collision;

  logic                  w_en1, w_en2;
  cmd_e                  w_cmd1, w_cmd2;
  logic                  w_wr1, w_wr2, w_rd1, w_rd2;
  logic                  w_collide;
  logic [BE-1:0]         w_lanes1, w_lanes2;
  logic [DATA_WIDTH-1:0] w_rdata1, w_rdata2;

  assign w_en1  = clken  & ~reset_req;
  assign w_en2  = clken2 & ~reset_req;
  assign w_cmd1 = decode_cmd(chipselect  & w_en1, read,  write);
  assign w_cmd2 = decode_cmd(chipselect2 & w_en2, read2, write2);
  assign w_wr1  = (w_cmd1 == CMD_WRITE);
  assign w_wr2  = (w_cmd2 == CMD_WRITE);
  assign w_rd1  = (w_cmd1 == CMD_READ);
  assign w_rd2  = (w_cmd2 == CMD_READ);

  // Collision merge: s1 owns every lane it enables, s2 fills the rest.
  assign w_collide = w_wr1 & w_wr2 & (address == address2);
  assign w_lanes1  = w_wr1 ? byteenable : '0;
  assign w_lanes2  = w_wr2 ? (byteenable2 & ~(w_collide ? byteenable : '0)) : '0;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BE; i++) begin
      if (w_lanes1[i]) begin
        r_mem[address][8*i +: 8] <= writedata[8*i +: 8];
      end
      if (w_lanes2[i]) begin
        r_mem[address2][8*i +: 8] <= writedata2[8*i +: 8];
      end
    end
  end

  // Sampled before this edge's writes land, so cross-port reads see old data.
  assign w_rdata1 = r_mem[address];
  assign w_rdata2 = r_mem[address2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_collision <= 1'b0;
    end else if (w_collide) begin
      r_collision <= 1'b1;
    end else if (collision_clr) begin
      r_collision <= 1'b0;
    end
  end

  assign collision = r_collision;

  onchip_mem_rdpipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rdpipe1 (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_en1),
    .i_valid (w_rd1),
    .i_data  (w_rdata1),
    .o_valid (readdatavalid),
    .o_data  (readdata)
  );

  onchip_mem_rdpipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rdpipe2 (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_en2),
    .i_valid (w_rd2),
    .i_data  (w_rdata2),
    .o_valid (readdatavalid2),
    .o_data  (readdata2)
  );

endmodule

// File: tb/tb_onchip_mem_dp_pipelined.sv
// Bench for onchip_mem_dp_pipelined: READ_LATENCY=1 and =2 instances share stimulus
// and are checked every cycle against a word-level memory/queue model.
module tb_onchip_mem_dp_pipelined;

  logic        clk = 1'b0;
  logic        reset, reset_req, collision_clr;
  logic [12:0] address, address2;
  logic [3:0]  byteenable, byteenable2;
  logic        chipselect, chipselect2, read, read2, write, write2, clken, clken2;
  logic [31:0] writedata, writedata2;

  logic [31:0] rdata  [2][2];
  logic        rvalid [2][2];
  logic        coll   [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  onchip_mem_dp_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(13), .READ_LATENCY(1), .INIT_FILE("")
  ) u_dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .clken(clken),
    .readdata(rdata[0][0]), .readdatavalid(rvalid[0][0]),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
    .read2(read2), .write2(write2), .writedata2(writedata2), .clken2(clken2),
    .readdata2(rdata[0][1]), .readdatavalid2(rvalid[0][1]),
    .collision(coll[0]), .collision_clr(collision_clr)
  );

  onchip_mem_dp_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(13), .READ_LATENCY(2), .INIT_FILE("")
  ) u_dut2 (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .clken(clken),
    .readdata(rdata[1][0]), .readdatavalid(rvalid[1][0]),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
    .read2(read2), .write2(write2), .writedata2(writedata2), .clken2(clken2),
    .readdata2(rdata[1][1]), .readdatavalid2(rvalid[1][1]),
    .collision(coll[1]), .collision_clr(collision_clr)
  );

  // ---------------- model: word memory + in-order return queues ----------------
  typedef struct {
    logic [31:0] d;
    int          rem;
  } item_t;

  logic [31:0] mem_m [int];
  item_t       q [4][$];      // k = latency_index*2 + port
  logic [31:0] seen [4][$];
  logic        coll_m = 1'b0;

  function automatic logic [31:0] mem_rd(input int a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    logic [1:0]  en, acc, wq, rq;
    int          a [2];
    logic [31:0] old [2];
    item_t       it;
    en   = {clken2, clken} & {2{~reset_req}};
    acc  = {chipselect2, chipselect} & en;
    wq   = acc & {write2, write};
    rq   = acc & ~{write2, write} & {read2, read};
    a[0] = int'(address);
    a[1] = int'(address2);
    old[0] = mem_rd(a[0]);
    old[1] = mem_rd(a[1]);
    if (reset) begin
      for (int k = 0; k < 4; k++) q[k].delete();
      coll_m = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (en[k % 2]) begin
          if (q[k].size() > 0 && q[k][0].rem == 0) q[k].delete(0);
          for (int j = 0; j < q[k].size(); j++) begin
            it = q[k][j];
            it.rem = it.rem - 1;
            q[k][j] = it;
          end
          if (rq[k % 2]) begin
            it.d   = old[k % 2];
            it.rem = k / 2 + 1;
            q[k].push_back(it);
          end
        end
      end
      if (wq[0] && wq[1] && a[0] == a[1]) coll_m = 1'b1;
      else if (collision_clr) coll_m = 1'b0;
    end
    // s2 first, then s1, so s1 owns any lane both enable.
    if (wq[1]) mem_m[a[1]] = merge(mem_rd(a[1]), writedata2, byteenable2);
    if (wq[0]) mem_m[a[0]] = merge(mem_rd(a[0]), writedata,  byteenable);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 4; k++) begin
        automatic int   p     = k % 2;
        automatic int   li    = k / 2;
        automatic logic en_n  = (p == 0 ? clken : clken2) & ~reset_req;
        automatic logic exp_v = en_n && (q[k].size() > 0) && (q[k][0].rem == 0);
        chk_bit($sformatf("readdatavalid lat%0d port%0d", li + 1, p + 1), rvalid[li][p], exp_v);
        if (exp_v)
          chk($sformatf("readdata lat%0d port%0d", li + 1, p + 1), rdata[li][p], q[k][0].d);
        if (rvalid[li][p] === 1'b1) seen[k].push_back(rdata[li][p]);
      end
      chk_bit("collision lat1", coll[0], coll_m);
      chk_bit("collision lat2", coll[1], coll_m);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_cmds();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0;
  endtask

  task automatic wr(input int p, input int unsigned a, input logic [31:0] d, input logic [3:0] be);
    if (p == 0) begin
      chipselect = 1'b1; write = 1'b1; read = 1'b0;
      address = 13'(a); writedata = d; byteenable = be;
    end else begin
      chipselect2 = 1'b1; write2 = 1'b1; read2 = 1'b0;
      address2 = 13'(a); writedata2 = d; byteenable2 = be;
    end
  endtask

  task automatic rd(input int p, input int unsigned a);
    if (p == 0) begin
      chipselect = 1'b1; write = 1'b0; read = 1'b1; address = 13'(a);
    end else begin
      chipselect2 = 1'b1; write2 = 1'b0; read2 = 1'b1; address2 = 13'(a);
    end
  endtask

  task automatic clear_seen();
    for (int k = 0; k < 4; k++) seen[k].delete();
  endtask

  task automatic expect_seen(input string nm, input int k, input int n, input logic [31:0] e0,
                             input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk($sformatf("%s k%0d pulses", nm, k), 32'(seen[k].size()), 32'(n));
    for (int i = 0; i < n && i < seen[k].size(); i++)
      chk($sformatf("%s k%0d word%0d", nm, k, i), seen[k][i], e[i]);
  endtask

  task automatic expect_both(input string nm, input int p, input int n, input logic [31:0] e0,
                             input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    expect_seen(nm, p, n, e0, e1, e2, e3);
    expect_seen(nm, p + 2, n, e0, e1, e2, e3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset_req = 1'b0; collision_clr = 1'b0;
    clken = 1'b1; clken2 = 1'b1;
    address = '0; address2 = '0; byteenable = '0; byteenable2 = '0;
    writedata = '0; writedata2 = '0;
    clr_cmds();
    step(3);
    reset = 1'b0;
    chk_on = 1'b1;

    // Reset state
    @(negedge clk);
    for (int li = 0; li < 2; li++) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("reset readdata lat%0d port%0d", li + 1, p + 1), rdata[li][p], 32'h0);
        chk_bit($sformatf("reset rdvalid lat%0d port%0d", li + 1, p + 1), rvalid[li][p], 1'b0);
      end
      chk_bit($sformatf("reset collision lat%0d", li + 1), coll[li], 1'b0);
    end

    // Write then read with exact latency
    wr(0, 5, 32'hDEADBEEF, 4'hF); step(1); clr_cmds();
    rd(0, 5); step(1); clr_cmds();
    @(negedge clk);
    chk_bit("t1 lat1 before N+1", rvalid[0][0], 1'b0);
    chk_bit("t1 lat2 before N+1", rvalid[1][0], 1'b0);
    step(1); @(negedge clk);
    chk_bit("t1 lat1 at N+1", rvalid[0][0], 1'b1);
    chk("t1 lat1 data", rdata[0][0], 32'hDEADBEEF);
    chk_bit("t1 lat2 at N+1", rvalid[1][0], 1'b0);
    step(1); @(negedge clk);
    chk_bit("t1 lat1 at N+2", rvalid[0][0], 1'b0);
    chk_bit("t1 lat2 at N+2", rvalid[1][0], 1'b1);
    chk("t1 lat2 data", rdata[1][0], 32'hDEADBEEF);
    step(2);

    // Byte lanes
    wr(0, 7, 32'h11223344, 4'hF); step(1); clr_cmds();
    wr(1, 7, 32'hAABBCCDD, 4'b0101); step(1); clr_cmds();
    clear_seen();
    rd(0, 7); step(1); clr_cmds(); step(4);
    expect_both("bytelane", 0, 1, 32'h11BB33DD, 32'h0, 32'h0, 32'h0);

    // Write collision, merged result, clear
    wr(0, 9, 32'h000000FF, 4'b0001); wr(1, 9, 32'hFFFFFF00, 4'hF); step(1); clr_cmds();
    @(negedge clk);
    chk_bit("collision set lat1", coll[0], 1'b1);
    chk_bit("collision set lat2", coll[1], 1'b1);
    clear_seen();
    rd(1, 9); step(1); clr_cmds(); step(4);
    expect_both("collide merge", 1, 1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    collision_clr = 1'b1; step(1); collision_clr = 1'b0;
    @(negedge clk);
    chk_bit("collision cleared", coll[0], 1'b0);

    // Set beats clear; different addresses do not collide
    wr(0, 9, 32'h000000FF, 4'b0001); wr(1, 9, 32'hFFFFFF00, 4'hF);
    collision_clr = 1'b1; step(1); clr_cmds(); collision_clr = 1'b0;
    @(negedge clk);
    chk_bit("collision set wins", coll[1], 1'b1);
    collision_clr = 1'b1; step(1); collision_clr = 1'b0;
    wr(0, 10, 32'h0A0A0A0A, 4'hF); wr(1, 11, 32'h0B0B0B0B, 4'hF); step(1); clr_cmds();
    @(negedge clk);
    chk_bit("no collision diff addr", coll[0], 1'b0);

    // Zero-byteenable write still collides; s2 data lands
    wr(0, 12, 32'h12345678, 4'h0); wr(1, 12, 32'hCAFEF00D, 4'hF); step(1); clr_cmds();
    clear_seen();
    rd(0, 12); step(1); clr_cmds(); step(4);
    chk_bit("be0 collision", coll[0], 1'b1);
    expect_both("be0 merge", 0, 1, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
    collision_clr = 1'b1; step(1); collision_clr = 1'b0;

    // Mixed-port read during write
    wr(0, 3, 32'h1, 4'hF); step(1); clr_cmds();
    clear_seen();
    wr(0, 3, 32'h5, 4'hF); rd(1, 3); step(1); clr_cmds();
    rd(1, 3); step(1); clr_cmds(); step(4);
    expect_both("mixed rdw", 1, 2, 32'h1, 32'h5, 32'h0, 32'h0);

    // Stall mid-burst on s1
    clear_seen();
    rd(0, 5); step(1);
    rd(0, 7); step(1);
    clken = 1'b0; rd(0, 9); step(2);
    clken = 1'b1; step(1);
    rd(0, 3); step(1); clr_cmds(); step(6);
    expect_both("stall burst", 0, 4, 32'hDEADBEEF, 32'h11BB33DD, 32'hFFFFFFFF, 32'h5);
    expect_both("stall other port", 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    // reset_req freezes both ports and blocks writes
    clear_seen();
    rd(0, 7); rd(1, 3); step(1); clr_cmds();
    reset_req = 1'b1; wr(0, 5, 32'h0, 4'hF); step(2); clr_cmds();
    reset_req = 1'b0; step(4);
    expect_both("reset_req s1", 0, 1, 32'h11BB33DD, 32'h0, 32'h0, 32'h0);
    expect_both("reset_req s2", 1, 1, 32'h5, 32'h0, 32'h0, 32'h0);
    clear_seen();
    rd(0, 5); step(1); clr_cmds(); step(4);
    expect_both("reset_req no write", 0, 1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);

    // Reset one cycle after accept discards in-flight reads
    clear_seen();
    rd(0, 7); rd(1, 9); step(1); clr_cmds();
    reset = 1'b1; step(1); reset = 1'b0;
    @(negedge clk);
    chk("post-reset readdata lat2 s1", rdata[1][0], 32'h0);
    chk("post-reset readdata lat2 s2", rdata[1][1], 32'h0);
    chk("post-reset readdata lat1 s1", rdata[0][0], 32'h0);
    step(4);
    expect_both("reset discard s1", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    expect_both("reset discard s2", 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    clear_seen();
    rd(0, 7); rd(1, 9); step(1); clr_cmds(); step(4);
    expect_both("reset keeps ram s1", 0, 1, 32'h11BB33DD, 32'h0, 32'h0, 32'h0);
    expect_both("reset keeps ram s2", 1, 1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
